// File: rtl/store_controller.sv
// Store controller: turns byte/half/word stores at any byte address into one
// or two word-aligned memory beats with byte enables, under ack handshake.
module store_controller (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_req,
    input  logic [2:0]  I_storesel,
    input  logic [31:0] I_addr,
    input  logic [31:0] I_data,
    output logic        O_busy,
    output logic        O_done,
    output logic        O_err,
    output logic        O_mem_we,
    output logic [31:0] O_mem_addr,
    output logic [31:0] O_mem_data,
    output logic [3:0]  O_mem_be,
    input  logic        I_mem_ack
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BEAT0 = 3'd1,
        BEAT1 = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [2:0] SEL_SB = 3'b000;
    localparam logic [2:0] SEL_SH = 3'b001;
    localparam logic [2:0] SEL_SW = 3'b010;

    state_t      state;
    state_t      state_next;
    logic        sel_valid;
    logic        accept;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [2:0]  sel_q;
    logic [3:0]  mask4;
    logic [31:0] data_sz;
    logic [7:0]  be8;
    logic [63:0] data64;
    logic [31:0] base_addr;

    always_comb begin
        sel_valid = (I_storesel == SEL_SB) || (I_storesel == SEL_SH) ||
                    (I_storesel == SEL_SW);
        accept    = (state == IDLE) && I_req && sel_valid && !I_rst;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the captured request is deliberately not reset; it is only read
    // in the beat states, which can be reached only through a fresh capture.
    always_ff @(posedge I_clk) begin
        if (accept) begin
            addr_q <= I_addr;
            data_q <= I_data;
            sel_q  <= I_storesel;
        end
    end

    // Spread the sized store across an 8-byte window starting at the
    // containing word; the upper half becomes the second beat if non-empty.
    always_comb begin
        mask4   = 4'b1111;
        data_sz = data_q;
        case (sel_q)
            SEL_SB: begin
                mask4   = 4'b0001;
                data_sz = {24'h0, data_q[7:0]};
            end
            SEL_SH: begin
                mask4   = 4'b0011;
                data_sz = {16'h0, data_q[15:0]};
            end
            default: begin
                mask4   = 4'b1111;
                data_sz = data_q;
            end
        endcase
        be8       = {4'b0000, mask4} << addr_q[1:0];
        data64    = {32'h0, data_sz} << {addr_q[1:0], 3'b000};
        base_addr = {addr_q[31:2], 2'b00};
    end

    // NOTE: every output and next-state is given a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        O_busy     = 1'b1;
        O_done     = 1'b0;
        O_err      = 1'b0;
        O_mem_we   = 1'b0;
        O_mem_addr = 32'h0;
        O_mem_data = 32'h0;
        O_mem_be   = 4'h0;
        case (state)
            IDLE: begin
                O_busy = 1'b0;
                if (I_req) begin
                    state_next = sel_valid ? BEAT0 : ERR;
                end
            end
            BEAT0: begin
                O_mem_we   = 1'b1;
                O_mem_addr = base_addr;
                O_mem_be   = be8[3:0];
                O_mem_data = data64[31:0];
                if (I_mem_ack) begin
                    state_next = (be8[7:4] != 4'h0) ? BEAT1 : DONE;
                end
            end
            BEAT1: begin
                O_mem_we   = 1'b1;
                O_mem_addr = base_addr + 32'd4;
                O_mem_be   = be8[7:4];
                O_mem_data = data64[63:32];
                if (I_mem_ack) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                O_done     = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                O_err      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_store_controller.sv
// Self-checking bench for store_controller: directed scenarios plus random
// stores checked against a byte-by-byte placement model.
module tb_store_controller;

    logic        I_clk;
    logic        I_rst;
    logic        I_req;
    logic [2:0]  I_storesel;
    logic [31:0] I_addr;
    logic [31:0] I_data;
    logic        O_busy;
    logic        O_done;
    logic        O_err;
    logic        O_mem_we;
    logic [31:0] O_mem_addr;
    logic [31:0] O_mem_data;
    logic [3:0]  O_mem_be;
    logic        I_mem_ack;

    int passed = 0;
    int total  = 0;

    int          m_nb;
    logic [31:0] m_addr [2];
    logic [3:0]  m_be   [2];
    logic [31:0] m_data [2];

    store_controller dut (
        .I_clk      (I_clk),
        .I_rst      (I_rst),
        .I_req      (I_req),
        .I_storesel (I_storesel),
        .I_addr     (I_addr),
        .I_data     (I_data),
        .O_busy     (O_busy),
        .O_done     (O_done),
        .O_err      (O_err),
        .O_mem_we   (O_mem_we),
        .O_mem_addr (O_mem_addr),
        .O_mem_data (O_mem_data),
        .O_mem_be   (O_mem_be),
        .I_mem_ack  (I_mem_ack)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, {31'h0, O_busy}, 32'h0);
        check({tag, "_done"}, {31'h0, O_done}, 32'h0);
        check({tag, "_err"},  {31'h0, O_err},  32'h0);
        check({tag, "_we"},   {31'h0, O_mem_we}, 32'h0);
        check({tag, "_addr"}, O_mem_addr, 32'h0);
        check({tag, "_data"}, O_mem_data, 32'h0);
        check({tag, "_be"},   {28'h0, O_mem_be}, 32'h0);
    endtask

    // Reference: place each stored byte at its own byte address, then group
    // bytes by the word they land in (the containing word or the next one).
    task automatic model(input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] data);
        int          size;
        logic [31:0] a;
        logic [31:0] base;
        int          beat;
        int          lane;
        size = (sel == 3'b000) ? 1 : (sel == 3'b001) ? 2 : 4;
        base = addr & 32'hFFFF_FFFC;
        m_addr[0] = base;
        m_addr[1] = base + 32'd4;
        m_be[0] = 4'h0;
        m_be[1] = 4'h0;
        m_data[0] = 32'h0;
        m_data[1] = 32'h0;
        for (int i = 0; i < size; i++) begin
            a    = addr + i;
            beat = ((a & 32'hFFFF_FFFC) == base) ? 0 : 1;
            lane = int'(a % 4);
            m_be[beat][lane] = 1'b1;
            m_data[beat][8*lane +: 8] = data[8*i +: 8];
        end
        m_nb = (m_be[1] != 4'h0) ? 2 : 1;
    endtask

    // Issue one valid store; w0/w1 are wait cycles before ack on each beat.
    // With disturb set, inputs and I_req are scrambled while busy.
    task automatic do_store(input string tag, input logic [2:0] sel, input logic [31:0] addr,
                            input logic [31:0] data, input int w0, input int w1, input bit disturb);
        int w;
        model(sel, addr, data);
        I_req      = 1'b1;
        I_storesel = sel;
        I_addr     = addr;
        I_data     = data;
        tick();
        I_req = 1'b0;
        for (int b = 0; b < m_nb; b++) begin
            w = (b == 0) ? w0 : w1;
            for (int k = 0; k <= w; k++) begin
                check({tag, "_we"},   {31'h0, O_mem_we}, 32'h1);
                check({tag, "_busy"}, {31'h0, O_busy},   32'h1);
                check({tag, "_done"}, {31'h0, O_done},   32'h0);
                check({tag, "_addr"}, O_mem_addr, m_addr[b]);
                check({tag, "_be"},   {28'h0, O_mem_be}, {28'h0, m_be[b]});
                check({tag, "_data"}, O_mem_data, m_data[b]);
                if (disturb) begin
                    I_addr     = $urandom;
                    I_data     = $urandom;
                    I_storesel = 3'($urandom_range(0, 7));
                    I_req      = 1'($urandom_range(0, 1));
                end
                I_mem_ack = (k == w);
                tick();
            end
        end
        I_req     = 1'b0;
        I_mem_ack = 1'($urandom_range(0, 1));
        check({tag, "_done_pulse"}, {31'h0, O_done},   32'h1);
        check({tag, "_done_we"},    {31'h0, O_mem_we}, 32'h0);
        check({tag, "_done_busy"},  {31'h0, O_busy},   32'h1);
        tick();
        I_mem_ack = 1'b0;
        check({tag, "_after_done"}, {31'h0, O_done}, 32'h0);
        check({tag, "_after_busy"}, {31'h0, O_busy}, 32'h0);
        check({tag, "_after_we"},   {31'h0, O_mem_we}, 32'h0);
    endtask

    task automatic do_invalid(input string tag, input logic [2:0] sel);
        I_req      = 1'b1;
        I_storesel = sel;
        I_addr     = $urandom;
        I_data     = $urandom;
        I_mem_ack  = 1'b1;
        tick();
        I_req = 1'b0;
        check({tag, "_err"},  {31'h0, O_err},    32'h1);
        check({tag, "_we"},   {31'h0, O_mem_we}, 32'h0);
        check({tag, "_done"}, {31'h0, O_done},   32'h0);
        check({tag, "_busy"}, {31'h0, O_busy},   32'h1);
        tick();
        I_mem_ack = 1'b0;
        check({tag, "_err_clr"},  {31'h0, O_err},    32'h0);
        check({tag, "_idle"},     {31'h0, O_busy},   32'h0);
        check({tag, "_we_clr"},   {31'h0, O_mem_we}, 32'h0);
    endtask

    initial begin
        logic [2:0]  sel;
        logic [31:0] addr;

        // Reset wins over a simultaneous valid request and ack.
        I_rst      = 1'b1;
        I_req      = 1'b1;
        I_storesel = 3'b010;
        I_addr     = 32'h100;
        I_data     = 32'hFFFF_FFFF;
        I_mem_ack  = 1'b1;
        tick();
        check_idle_zero("reset");
        tick();
        check_idle_zero("reset_hold");
        I_rst     = 1'b0;
        I_req     = 1'b0;
        I_mem_ack = 1'b0;
        tick();
        check_idle_zero("post_reset");

        do_store("sw_aligned", 3'b010, 32'h0000_0100, 32'h8080_8080, 0, 0, 1'b0);
        do_store("sb_lane3",   3'b000, 32'h0000_0103, 32'h1234_5680, 0, 0, 1'b0);
        do_store("sh_lane2",   3'b001, 32'h0000_0102, 32'h1234_BEEF, 0, 0, 1'b0);
        do_store("sw_misalgn", 3'b010, 32'h0000_0203, 32'hAABB_CCDD, 0, 0, 1'b0);
        do_store("backpress",  3'b010, 32'h0000_0100, 32'h1357_9BDF, 3, 0, 1'b1);
        do_store("sw_wrap",    3'b010, 32'hFFFF_FFFE, 32'hCAFE_F00D, 1, 2, 1'b1);
        do_invalid("inv_011", 3'b011);
        do_invalid("inv_111", 3'b111);

        // Reset while BEAT1 of the misaligned word store is waiting for ack.
        I_req      = 1'b1;
        I_storesel = 3'b010;
        I_addr     = 32'h0000_0203;
        I_data     = 32'hAABB_CCDD;
        tick();
        I_req = 1'b0;
        check("rst_mid_b0_addr", O_mem_addr, 32'h0000_0200);
        I_mem_ack = 1'b1;
        tick();
        I_mem_ack = 1'b0;
        check("rst_mid_b1_addr", O_mem_addr, 32'h0000_0204);
        check("rst_mid_b1_be",   {28'h0, O_mem_be}, 32'h7);
        I_rst = 1'b1;
        tick();
        I_rst = 1'b0;
        check_idle_zero("rst_mid");
        for (int i = 0; i < 3; i++) begin
            I_mem_ack = 1'b1;
            tick();
            check("rst_mid_no_done", {31'h0, O_done}, 32'h0);
            check("rst_mid_no_we",   {31'h0, O_mem_we}, 32'h0);
        end
        I_mem_ack = 1'b0;
        do_store("after_rst", 3'b010, 32'h0000_0100, 32'h0BAD_F00D, 0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                do_invalid("rnd_inv", 3'($urandom_range(3, 7)));
            end else begin
                sel  = 3'($urandom_range(0, 2));
                addr = $urandom;
                if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
                do_store("rnd", sel, addr, $urandom,
                         $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
